// File: rtl/timer_apb_pkg.sv
// timer_apb_pkg: shared definitions for the timer APB front-end.
// FSM state encoding, timer register indices and the wait-state limit.
package timer_apb_pkg;

  // Bus-interface FSM states
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Register indices as seen on o_addr (paddr[5:2])
  localparam logic [3:0] TCNT_0  = 4'h0;
  localparam logic [3:0] TCNT_1  = 4'h1;
  localparam logic [3:0] TCORA_0 = 4'h2;
  localparam logic [3:0] TCORA_1 = 4'h3;
  localparam logic [3:0] TCORB_0 = 4'h4;
  localparam logic [3:0] TCORB_1 = 4'h5;
  localparam logic [3:0] TCCR_0  = 4'h6;
  localparam logic [3:0] TCCR_1  = 4'h7;
  localparam logic [3:0] TCR_0   = 4'h8;
  localparam logic [3:0] TCR_1   = 4'h9;
  localparam logic [3:0] TCSR_0  = 4'hA;
  localparam logic [3:0] TCSR_1  = 4'hB;

  // Largest wait-state count the 3-bit access counter can express
  localparam int WAIT_STATES_MAX = 7;

endpackage

// File: rtl/timer_apb_decode.sv
// timer_apb_decode: combinational APB address decode.
// Word-spaced registers: index is paddr[5:2]; the byte lane bits are ignored.
// An address is mapped only if all bits above bit 5 are zero and the index
// falls below NUM_REGS.
module timer_apb_decode #(
  parameter int APB_AW   = 12,
  parameter int NUM_REGS = 12
) (
  input  logic [APB_AW-1:0] i_paddr,
  output logic [3:0]        o_idx,
  output logic              o_valid
);

  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

  // Byte-lane bits carry no information for word registers
  logic unused_byte_lane;
  assign unused_byte_lane = ^i_paddr[1:0];

  assign o_idx   = i_paddr[5:2];
  assign o_valid = ((i_paddr >> 6) == '0) && ({1'b0, o_idx} < NUM_REGS_W);

endmodule

// File: rtl/timer_apb_if.sv
// timer_apb_if: APB3 slave front-end for the 8-bit dual-channel timer.
// Turns APB setup/access transfers into o_wren/o_addr/o_datain strobes and
// returns i_reg_rdata on reads, with WAIT_STATES extra access cycles.
// Optional macro TIMER_APB_SLVERR_EN: drive o_pslverr for unmapped addresses;
// when undefined o_pslverr is tied low (unmapped accesses are still harmless).
module timer_apb_if
  import timer_apb_pkg::*;
#(
  parameter int APB_AW      = 12,
  parameter int WAIT_STATES = 1,
  parameter int NUM_REGS    = 12
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [APB_AW-1:0] i_paddr,
  input  logic [31:0]       i_pwdata,
  output logic [31:0]       o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic              o_wren,
  output logic [7:0]        o_addr,
  output logic [7:0]        o_datain,
  input  logic [7:0]        i_reg_rdata
);

  // Out-of-range settings saturate rather than wrap the 3-bit counter
  localparam int         WS_EFF    = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  localparam logic [2:0] WAIT_LAST = 3'(WS_EFF);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       write_q, write_d;
  logic       valid_q, valid_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] datain_q, datain_d;

  logic [3:0] dec_idx;
  logic       dec_valid;
  logic       done;
  logic       ready;

  // Upper write-data bits have no destination in the 8-bit register file
  logic unused_pwdata_hi;
  assign unused_pwdata_hi = ^i_pwdata[31:8];

  timer_apb_decode #(
    .APB_AW   (APB_AW),
    .NUM_REGS (NUM_REGS)
  ) u_decode (
    .i_paddr (i_paddr),
    .o_idx   (dec_idx),
    .o_valid (dec_valid)
  );

  // Completion is decoded straight from registered state so the master sees
  // o_pready in the same cycle the last wait state expires.
  assign done  = (cnt_q == WAIT_LAST);
  assign ready = (state_q == ACCESS) && done && i_psel && i_penable;

  assign o_pready = ready;
  assign o_wren   = ready && write_q && valid_q;
  assign o_prdata = (ready && !write_q && valid_q) ? {24'b0, i_reg_rdata} : 32'b0;
  assign o_addr   = {4'b0, addr_q};
  assign o_datain = datain_q;

`ifdef TIMER_APB_SLVERR_EN
  assign o_pslverr = ready && !valid_q;
`else
  assign o_pslverr = 1'b0;
`endif

  // Next-state: capture on setup, count wait states, leave on done or abort
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    datain_d = datain_q;
    case (state_q)
      IDLE: begin
        // psel with penable already high is a protocol error and is ignored
        if (i_psel && !i_penable) begin
          state_d  = ACCESS;
          cnt_d    = 3'd0;
          write_d  = i_pwrite;
          valid_d  = dec_valid;
          addr_d   = dec_idx;
          datain_d = i_pwdata[7:0];
        end
      end
      ACCESS: begin
        if (!(i_psel && i_penable)) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      write_q  <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= 4'd0;
      datain_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      datain_q <= datain_d;
    end
  end

endmodule

// File: tb/tb_timer_apb_if.sv
// tb_timer_apb_if: three instances (WAIT_STATES 0, 1, 3) share one APB
// stimulus stream and are checked every cycle against a transfer-level model.
module tb_timer_apb_if;

  localparam int NI   = 3;
  localparam int NREG = 12;

`ifdef TIMER_APB_SLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = 12'h0;
  logic [31:0] pwdata = 32'h0;
  logic [7:0]  rdata = 8'h0;
  bit          rand_rd = 1'b0;

  logic [31:0] prdata [NI];
  logic        pready [NI];
  logic        pslverr [NI];
  logic        wren [NI];
  logic [7:0]  oaddr [NI];
  logic [7:0]  odatain [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    timer_apb_if #(
      .APB_AW      (12),
      .WAIT_STATES (ws_of(gi)),
      .NUM_REGS    (NREG)
    ) u_dut (
      .i_clk_sys   (clk),
      .i_rst_n     (rst_n),
      .i_psel      (psel),
      .i_penable   (penable),
      .i_pwrite    (pwrite),
      .i_paddr     (paddr),
      .i_pwdata    (pwdata),
      .o_prdata    (prdata[gi]),
      .o_pready    (pready[gi]),
      .o_pslverr   (pslverr[gi]),
      .o_wren      (wren[gi]),
      .o_addr      (oaddr[gi]),
      .o_datain    (odatain[gi]),
      .i_reg_rdata (rdata)
    );
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int wren_cnt [NI] = '{0, 0, 0};

  // Transfer-level model: a transfer starts in its setup period and must
  // complete exactly ws+1 periods later if the master keeps psel&penable up.
  bit m_busy [NI] = '{0, 0, 0};
  int m_start [NI] = '{0, 0, 0};
  bit m_wr [NI] = '{0, 0, 0};
  bit m_val [NI] = '{0, 0, 0};
  int m_idx [NI] = '{0, 0, 0};
  int m_dat [NI] = '{0, 0, 0};

  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0;
        m_wr[k]   <= 1'b0;
        m_val[k]  <= 1'b0;
        m_idx[k]  <= 0;
        m_dat[k]  <= 0;
      end else if (!m_busy[k]) begin
        if (psel && !penable) begin
          m_busy[k]  <= 1'b1;
          m_start[k] <= cyc;
          m_wr[k]    <= pwrite;
          m_val[k]   <= (int'(paddr) < 4 * NREG);
          m_idx[k]   <= (int'(paddr) / 4) % 16;
          m_dat[k]   <= int'(pwdata % 256);
        end
      end else if (!(psel && penable) || (cyc - m_start[k] == ws_of(k) + 1)) begin
        m_busy[k] <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  // Per-cycle comparison of every output of every instance against the model
  always @(negedge clk) begin
    bit rdy;
    logic [31:0] e_rd;
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        rdy  = m_busy[k] && psel && penable && (cyc - m_start[k] == ws_of(k) + 1);
        e_rd = (rdy && !m_wr[k] && m_val[k]) ? {24'b0, rdata} : 32'h0;
        cmp("pready", k, 32'(pready[k]), 32'(rdy));
        cmp("wren", k, 32'(wren[k]), 32'(rdy && m_wr[k] && m_val[k]));
        cmp("prdata", k, prdata[k], e_rd);
        cmp("pslverr", k, 32'(pslverr[k]), 32'(ERR_EN && rdy && !m_val[k]));
        cmp("addr", k, 32'(oaddr[k]), 32'(m_idx[k]));
        cmp("datain", k, 32'(odatain[k]), 32'(m_dat[k]));
      end
    end
    for (int k = 0; k < NI; k++) wren_cnt[k] <= wren_cnt[k] + int'(wren[k]);
  end

  task automatic drive(input bit s, input bit e, input bit w, input logic [11:0] a, input logic [31:0] d);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rd) rdata = 8'($urandom);
  endtask

  task automatic xfer(input bit w, input logic [11:0] a, input logic [31:0] d, input int len);
    drive(1'b1, 1'b0, w, a, d);
    step();
    penable = 1'b1;
    repeat (len) step();
  endtask

  initial begin
    int c0, c1, c3, gap, len;
    logic [11:0] a;
    bit w;

    repeat (3) step();
    chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      cmp("rst_pready", k, 32'(pready[k]), 32'd0);
      cmp("rst_addr", k, 32'(oaddr[k]), 32'd0);
      cmp("rst_prdata", k, prdata[k], 32'd0);
    end
    step();
    rst_n = 1'b1;
    step();

    // Write 0x5A to index 2
    drive(1'b1, 1'b0, 1'b1, 12'h008, 32'h0000_005A);
    step();
    penable = 1'b1;
    @(negedge clk);
    cmp("t1_ws0_rdy", 0, 32'(pready[0]), 32'd1);
    cmp("t1_ws0_wren", 0, 32'(wren[0]), 32'd1);
    cmp("t1_ws1_early", 1, 32'(pready[1]), 32'd0);
    step();
    @(negedge clk);
    cmp("t1_ws1_rdy", 1, 32'(pready[1]), 32'd1);
    cmp("t1_ws1_wren", 1, 32'(wren[1]), 32'd1);
    cmp("t1_ws1_addr", 1, 32'(oaddr[1]), 32'h02);
    cmp("t1_ws1_data", 1, 32'(odatain[1]), 32'h5A);
    cmp("t1_ws1_err", 1, 32'(pslverr[1]), 32'd0);
    step();
    step();
    @(negedge clk);
    cmp("t1_ws3_wren", 2, 32'(wren[2]), 32'd1);
    step();
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();

    // Read index 0xA returning 0xC3
    rdata = 8'hC3;
    drive(1'b1, 1'b0, 1'b0, 12'h028, 32'h0);
    step();
    penable = 1'b1;
    @(negedge clk);
    cmp("t2_ws0_rd", 0, prdata[0], 32'h0000_00C3);
    cmp("t2_ws0_rdy", 0, 32'(pready[0]), 32'd1);
    repeat (4) step();
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();

    // Unmapped write, index 0xC
    drive(1'b1, 1'b0, 1'b1, 12'h030, 32'h0000_00EE);
    step();
    penable = 1'b1;
    step();
    @(negedge clk);
    cmp("t3_rdy", 1, 32'(pready[1]), 32'd1);
    cmp("t3_err", 1, 32'(pslverr[1]), 32'(ERR_EN));
    cmp("t3_wren", 1, 32'(wren[1]), 32'd0);
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();

    // Back-to-back write then read on the 3-wait-state instance
    c3 = wren_cnt[2];
    drive(1'b1, 1'b0, 1'b1, 12'h000, 32'h0000_00A5);
    step();
    penable = 1'b1;
    repeat (3) step();
    @(negedge clk);
    cmp("t4_wr_rdy", 2, 32'(pready[2]), 32'd1);
    step();
    rdata = 8'h77;
    drive(1'b1, 1'b0, 1'b0, 12'h004, 32'h0);
    step();
    penable = 1'b1;
    repeat (3) step();
    @(negedge clk);
    cmp("t4_rd_rdy", 2, 32'(pready[2]), 32'd1);
    cmp("t4_rd_data", 2, prdata[2], 32'h0000_0077);
    step();
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();
    cmp("t4_wren_pulses", 2, 32'(wren_cnt[2] - c3), 32'd1);

    // Abort in the second access cycle
    c3 = wren_cnt[2];
    drive(1'b1, 1'b0, 1'b1, 12'h010, 32'h0000_0033);
    step();
    penable = 1'b1;
    step();
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    @(negedge clk);
    cmp("t5_rdy", 2, 32'(pready[2]), 32'd0);
    cmp("t5_data_held", 2, 32'(odatain[2]), 32'h33);
    repeat (3) step();
    cmp("t5_no_wren", 2, 32'(wren_cnt[2] - c3), 32'd0);

    // Reset during access; psel/penable left high afterwards
    drive(1'b1, 1'b0, 1'b1, 12'h024, 32'h0000_0099);
    step();
    penable = 1'b1;
    rst_n = 1'b0;
    c1 = wren_cnt[1];
    c3 = wren_cnt[2];
    step();
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      cmp("t6_addr", k, 32'(oaddr[k]), 32'd0);
      cmp("t6_data", k, 32'(odatain[k]), 32'd0);
      cmp("t6_rdy", k, 32'(pready[k]), 32'd0);
    end
    repeat (3) step();
    cmp("t6_drop1", 1, 32'(wren_cnt[1] - c1), 32'd0);
    cmp("t6_drop3", 2, 32'(wren_cnt[2] - c3), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();

    // Randomized traffic, including protocol errors, short access phases
    // (aborts on slower instances) and occasional resets
    rand_rd = 1'b1;
    for (int t = 0; t < 400; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        if ($urandom_range(0, 5) == 0) drive(1'b1, 1'b1, 1'b1, 12'($urandom), $urandom);
        else drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        step();
      end
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) a = 12'($urandom);
      else a = 12'($urandom_range(0, 63));
      w = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 5);
      xfer(w, a, $urandom, len);
    end
    drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    step();
    step();
    c0 = wren_cnt[0];
    cmp("wren_seen", 0, 32'(c0 > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_apb_if.md
Name: timer_apb_if

Overview:
- APB3 slave front-end for the 8-bit dual-channel timer register file.
- Converts APB setup/access transfers into the timer's register-bus signals (o_wren, o_addr, o_datain).
- Returns read data from the timer's register read-mux output (i_reg_rdata), with programmable wait states and an error response for unmapped addresses.
- Sits directly upstream of the timer top; its outputs drive the timer's write-enable, address and data inputs.

Parameters:
- APB_AW, 12: APB address width. Registers are word-spaced; the register index is paddr[5:2].
- WAIT_STATES, 1: number of extra ACCESS cycles before o_pready rises. Legal range 0..7.
- NUM_REGS, 12: register indices 0..NUM_REGS-1 are mapped; indices NUM_REGS..15 are unmapped.

Ports:
- i_clk_sys  in  1  system clock; single clock domain.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_psel  in  1  APB select.
- i_penable  in  1  APB enable.
- i_pwrite  in  1  1 = write, 0 = read.
- i_paddr  in  APB_AW  APB byte address.
- i_pwdata  in  32  write data; only bits [7:0] are used.
- o_prdata  out  32  read data: {24'b0, byte}.
- o_pready  out  1  transfer complete.
- o_pslverr  out  1  error response, valid only while o_pready=1.
- o_wren  out  1  one-cycle write strobe to the timer registers.
- o_addr  out  8  register index {4'b0, paddr[5:2]}.
- o_datain  out  8  register write data.
- i_reg_rdata  in  8  timer register read-mux output for the current o_addr.

Behaviour:
- Reset (i_rst_n=0 sampled at a clock edge):
  - state=IDLE, wait counter=0.
  - o_addr=0, o_datain=0, o_wren=0, o_pready=0, o_pslverr=0, o_prdata=0.
- FSM states: IDLE, ACCESS. State is encoded in the shared package.
- IDLE:
  - On i_psel=1 and i_penable=0, at the clock edge: latch write flag, o_addr, o_datain=i_pwdata[7:0], and the valid flag; set counter=0; go to ACCESS.
  - valid = (paddr[APB_AW-1:6]==0) && (paddr[5:2] < NUM_REGS). paddr[1:0] is ignored.
- IDLE protocol error: i_psel=1 with i_penable=1 is ignored. The FSM stays in IDLE; no strobe, no o_pready.
- ACCESS:
  - done = (counter==WAIT_STATES).
  - Counter increments each ACCESS cycle while not done.
  - o_pready = done && i_psel && i_penable. This is decoded from registered state, with no register stage.
  - Total latency from the setup cycle to o_pready is 1+WAIT_STATES cycles.
  - On the edge where o_pready=1, return to IDLE.
- Write:
  - o_wren = o_pready && write && valid. It is high for exactly one cycle per transfer, so the timer captures o_datain at that edge.
  - An invalid write produces no strobe.
- Read:
  - While o_pready=1 and read: o_prdata = valid ? {24'b0, i_reg_rdata} : 0.
  - o_prdata is 0 at all other times.
  - The returned value is the register value in the completion cycle. TCNT may have advanced during the wait states.
- Stability: o_addr and o_datain hold from the setup-capture edge until the next setup capture. They are not cleared in IDLE.
- Back-to-back transfers: setup in the cycle after completion is accepted from IDLE with no bubble beyond APB's mandatory setup cycle.
- Abort: i_psel=0 or i_penable=0 while in ACCESS returns to IDLE next edge with no strobe and no o_pready.
- Reset mid-transfer: immediate return to the reset values on the edge; a pending write is dropped.

Optional Feature:
- Macro: TIMER_APB_SLVERR_EN.
- Defined: o_pslverr = o_pready && !valid.
- Undefined: o_pslverr is tied to 0. Invalid writes are still suppressed and invalid reads still return 0.

Decomposition:
- Package timer_apb_pkg contains:
  - the state enum {IDLE, ACCESS};
  - register index localparams: TCNT_0=0x0, TCNT_1=0x1, TCORA_0=0x2, TCORA_1=0x3, TCORB_0=0x4, TCORB_1=0x5, TCCR_0=0x6, TCCR_1=0x7, TCR_0=0x8, TCR_1=0x9, TCSR_0=0xA, TCSR_1=0xB;
  - the WAIT_STATES maximum constant (7).
- One sub-module, timer_apb_decode: combinational paddr -> {index, valid}. The FSM and counter stay in the top.

Test Plan:
- Write, WAIT_STATES=1: paddr=0x008, pwdata=0x5A. Expect o_pready 2 cycles after setup, o_wren for 1 cycle with o_addr=0x02, o_datain=0x5A, o_pslverr=0.
- Read, WAIT_STATES=0: paddr=0x028, i_reg_rdata=0xC3. Expect o_pready in the first ACCESS cycle with o_prdata=0x000000C3.
- Unmapped write to paddr=0x030 (index 0xC), with TIMER_APB_SLVERR_EN defined: expect o_pready=1, o_pslverr=1, o_wren=0. With the macro undefined: expect o_pslverr=0.
- Back-to-back write to 0x000 then read from 0x004, WAIT_STATES=3: expect each transfer to complete 4 cycles after its setup and exactly one o_wren pulse.
- Abort and reset: drop i_psel in the 2nd ACCESS cycle, WAIT_STATES=3. Expect no o_wren or o_pready and return to IDLE. Separately, assert i_rst_n=0 in ACCESS: expect all outputs 0 on the next edge.
